// File: rtl/vcbd_ndig_updn.sv
// rtl/vcbd_ndig_updn.sv - N-digit cascadable up/down counter with per-digit radix
module vcbd_ndig_updn #(
  parameter int NDIG = 2,
  parameter int DW   = 4,
  parameter int BASE = 10
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 ce,
  input  logic                 s,
  input  logic                 ld,
  input  logic                 up,
  input  logic [NDIG*DW-1:0]   D,
  output logic [NDIG*DW-1:0]   Q,
  output logic                 TC,
  output logic                 CEO,
  output logic                 WRAP
);

  if (BASE > (1 << DW) || BASE < 2) begin : g_bad_base
    $error("vcbd_ndig_updn: BASE must lie in 2..2**DW");
  end

  localparam logic [DW-1:0] MAXD = DW'(BASE - 1);

  logic [NDIG*DW-1:0] q_next;
  logic [DW-1:0]      dk;
  logic [DW-1:0]      dd;
  logic               chain;
  logic               all_max;
  logic               all_zero;

  // chain carries "every lower digit is at its limit" up the ripple
  always_comb begin
    q_next   = Q;
    dk       = '0;
    dd       = '0;
    chain    = 1'b1;
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      dk = Q[k*DW +: DW];
      dd = D[k*DW +: DW];
      if (s) begin
        q_next[k*DW +: DW] = MAXD;
      end else if (ld) begin
        q_next[k*DW +: DW] = (dd > MAXD) ? MAXD : dd;
      end else if (ce && chain) begin
        if (up) q_next[k*DW +: DW] = (dk >= MAXD) ? '0 : dk + 1'b1;
        else    q_next[k*DW +: DW] = (dk == '0) ? MAXD : dk - 1'b1;
      end
      // an out-of-range digit carries like BASE-1 so it falls back in range
      chain    = chain & (up ? (dk >= MAXD) : (dk == '0));
      all_max  = all_max & (dk == MAXD);
      all_zero = all_zero & (dk == '0);
    end
  end

  assign TC  = up ? all_max : all_zero;
  assign CEO = ce & TC;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else begin
      Q    <= q_next;
      WRAP <= ce & ~s & ~ld & TC;
    end
  end

endmodule

// File: tb/tb_vcbd_ndig_updn.sv
// tb/tb_vcbd_ndig_updn.sv - self-checking bench for vcbd_ndig_updn (BCD, hex, cascaded)
module tb_vcbd_ndig_updn;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  // decimal 2-digit instance
  logic       ce = 0, s = 0, ld = 0, up = 1;
  logic [7:0] d = 0;
  logic [7:0] q;
  logic       tc, ceo, wrap;

  // hex 2-digit instance
  logic       ce_h = 0, ld_h = 0;
  logic [7:0] d_h = 0;
  logic [7:0] q_h;
  logic       tc_h, ceo_h, wrap_h;

  // cascaded pair forming a 4-digit decimal counter
  logic        ce_c = 0, ld_c = 0;
  logic [15:0] d_c = 0;
  logic [7:0]  q_lo, q_hi;
  logic        tc_lo, ceo_lo, wrap_lo, tc_hi, ceo_hi, wrap_hi;

  vcbd_ndig_updn #(.NDIG(2), .DW(4), .BASE(10)) dut (
    .clk(clk), .clr(clr), .ce(ce), .s(s), .ld(ld), .up(up), .D(d),
    .Q(q), .TC(tc), .CEO(ceo), .WRAP(wrap));

  vcbd_ndig_updn #(.NDIG(2), .DW(4), .BASE(16)) dut_hex (
    .clk(clk), .clr(clr), .ce(ce_h), .s(1'b0), .ld(ld_h), .up(1'b1), .D(d_h),
    .Q(q_h), .TC(tc_h), .CEO(ceo_h), .WRAP(wrap_h));

  vcbd_ndig_updn #(.NDIG(2), .DW(4), .BASE(10)) dut_lo (
    .clk(clk), .clr(clr), .ce(ce_c), .s(1'b0), .ld(ld_c), .up(1'b1), .D(d_c[7:0]),
    .Q(q_lo), .TC(tc_lo), .CEO(ceo_lo), .WRAP(wrap_lo));

  vcbd_ndig_updn #(.NDIG(2), .DW(4), .BASE(10)) dut_hi (
    .clk(clk), .clr(clr), .ce(ceo_lo), .s(1'b0), .ld(ld_c), .up(1'b1), .D(d_c[15:8]),
    .Q(q_hi), .TC(tc_hi), .CEO(ceo_hi), .WRAP(wrap_hi));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc2(input int v, input int b);
    logic [3:0] hi, lo;
    lo = 4'(v % b);
    hi = 4'((v / b) % b);
    return {hi, lo};
  endfunction

  function automatic int ldval(input logic [7:0] dv, input int b);
    int lo, hi;
    lo = int'(dv[3:0]);
    hi = int'(dv[7:4]);
    if (lo >= b) lo = b - 1;
    if (hi >= b) hi = b - 1;
    return hi * b + lo;
  endfunction

  // Value-level model: each counter is an integer modulo BASE^NDIG
  int m_d = 0, m_h = 0, m_c = 0;
  logic w_d = 0, w_h = 0, w_lo = 0, w_hi = 0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_d = 0; m_h = 0; m_c = 0;
      w_d = 0; w_h = 0; w_lo = 0; w_hi = 0;
    end else begin
      w_d = 0;
      if (s) m_d = 99;
      else if (ld) m_d = ldval(d, 10);
      else if (ce) begin
        w_d = up ? (m_d == 99) : (m_d == 0);
        m_d = up ? (m_d + 1) % 100 : (m_d + 99) % 100;
      end
      w_h = 0;
      if (ld_h) m_h = ldval(d_h, 16);
      else if (ce_h) begin
        w_h = (m_h == 255);
        m_h = (m_h + 1) % 256;
      end
      w_lo = 0; w_hi = 0;
      if (ld_c) m_c = ldval(d_c[15:8], 10) * 100 + ldval(d_c[7:0], 10);
      else if (ce_c) begin
        w_lo = (m_c % 100 == 99);
        w_hi = (m_c == 9999);
        m_c = (m_c + 1) % 10000;
      end
    end
  end

  always @(negedge clk) begin
    chk("dec_q", q, enc2(m_d, 10));
    chk("dec_tc", tc, up ? (m_d == 99) : (m_d == 0));
    chk("dec_ceo", ceo, ce & (up ? (m_d == 99) : (m_d == 0)));
    chk("dec_wrap", wrap, w_d);
    chk("hex_q", q_h, enc2(m_h, 16));
    chk("hex_tc", tc_h, m_h == 255);
    chk("hex_ceo", ceo_h, ce_h & (m_h == 255));
    chk("hex_wrap", wrap_h, w_h);
    chk("cas_q", {q_hi, q_lo}, {enc2(m_c / 100, 10), enc2(m_c % 100, 10)});
    chk("cas_tc_lo", tc_lo, m_c % 100 == 99);
    chk("cas_tc_hi", tc_hi, m_c / 100 == 99);
    chk("cas_ceo", ceo_hi, ce_c & (m_c == 9999));
    chk("cas_wrap_lo", wrap_lo, w_lo);
    chk("cas_wrap_hi", wrap_hi, w_hi);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2 clr = 1;
    tick(1);
    chk("rst_q", q, 8'h00);
    chk("rst_tc_up", tc, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    #1 clr = 0; ce = 1; up = 1;
    tick(99);
    chk("up99_q", q, 8'h99);
    chk("up99_tc", tc, 1'b1);
    chk("up99_ceo", ceo, 1'b1);
    tick(1);
    chk("roll_q", q, 8'h00);
    chk("roll_wrap", wrap, 1'b1);
    tick(1);
    chk("roll_wrap_pulse", wrap, 1'b0);

    #1 ce = 0; clr = 1;
    tick(1);
    #1 clr = 0; up = 0;
    tick(1);
    chk("dn0_tc", tc, 1'b1);
    chk("dn0_ceo_off", ceo, 1'b0);
    #1 ce = 1;
    tick(1);
    chk("dn_q", q, 8'h99);
    chk("dn_wrap", wrap, 1'b1);

    #1 up = 1; s = 1;
    tick(1);
    chk("set_q", q, 8'h99);
    chk("set_tc", tc, 1'b1);
    chk("set_wrap", wrap, 1'b0);
    #1 s = 0;
    tick(1);
    chk("post_set_q", q, 8'h00);
    chk("post_set_wrap", wrap, 1'b1);

    #1 ce = 0; ld = 1; d = 8'h3C;
    tick(1);
    chk("ld_clamp", q, 8'h39);
    #1 s = 1;
    tick(1);
    chk("s_over_ld", q, 8'h99);
    #1 s = 0; ld = 0;
    tick(1);
    chk("hold_q", q, 8'h99);
    chk("hold_ceo", ceo, 1'b0);

    #1 ld = 1; d = 8'h57;
    tick(1);
    #1 ld = 0; ce = 1; up = 1;
    tick(1);
    chk("dir_up", q, 8'h58);
    #1 up = 0;
    tick(1);
    chk("dir_dn", q, 8'h57);
    #1 ce = 0;
    @(posedge clk);
    #3 clr = 1;
    #1;
    chk("aclr_q", q, 8'h00);
    chk("aclr_wrap", wrap, 1'b0);
    tick(1);
    #1 clr = 0; up = 1; ce = 1;
    tick(1);
    chk("after_clr_q", q, 8'h01);
    #1 ce = 0;

    #1 ld_h = 1; d_h = 8'h0F;
    tick(1);
    #1 ld_h = 0; ce_h = 1;
    tick(1);
    chk("hex_carry", q_h, 8'h10);
    #1 ld_h = 1; d_h = 8'hFF; ce_h = 0;
    tick(1);
    chk("hex_tc_ff", tc_h, 1'b1);
    chk("hex_ceo_ce0", ceo_h, 1'b0);
    #1 ld_h = 0; ce_h = 1;
    tick(1);
    chk("hex_roll", q_h, 8'h00);
    chk("hex_wrap_lit", wrap_h, 1'b1);
    #1 ce_h = 0;

    #1 ld_c = 1; d_c = 16'h0099;
    tick(1);
    #1 ld_c = 0; ce_c = 1;
    tick(1);
    chk("cas_carry", {q_hi, q_lo}, 16'h0100);
    #1 ld_c = 1; d_c = 16'h9998;
    tick(1);
    #1 ld_c = 0;
    tick(1);
    chk("cas_9999", {q_hi, q_lo}, 16'h9999);
    chk("cas_ceo_lit", ceo_hi, 1'b1);
    tick(1);
    chk("cas_roll", {q_hi, q_lo}, 16'h0000);
    chk("cas_wrap_lit", wrap_hi, 1'b1);
    #1 ce_c = 0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vcbd_ndig_updn.md
Name: vcbd_ndig_updn

Overview:
- Parametrised successor to the single-digit 4-bit cascadable counter family.
- N-digit up/down counter with a configurable radix per digit (decimal or binary/hex), parallel load, synchronous set and asynchronous clear.
- Provides terminal-count (TC) and clock-enable-out (CEO) outputs so several instances can cascade, as the single-digit parts do.
- Sits in the counter/timer datapath and feeds display and timebase logic.

Parameters:
- NDIG, 2, number of cascaded digits (1..8).
- DW, 4, bits per digit.
- BASE, 10, radix of each digit (2..2^DW); 10 gives BCD, 16 gives binary.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high clear; all digits go to 0.
- ce  in  1  count enable.
- s  in  1  synchronous set; all digits go to BASE-1.
- ld  in  1  synchronous parallel load from D.
- up  in  1  direction; 1 counts up, 0 counts down.
- D  in  NDIG*DW  load data; digit 0 is in the LSBs.
- Q  out  NDIG*DW  counter value; digit k is in Q[k*DW +: DW].
- TC  out  1  terminal count for the current direction.
- CEO  out  1  ce & TC, cascade enable to the next stage.
- WRAP  out  1  registered one-cycle pulse after the counter wraps.

Behaviour:
- Reset: clr high forces Q=0 and WRAP=0 immediately, with no clock needed. With up=1, TC=0 and CEO=0 while in reset. With up=0, TC=1 (the count is 0); CEO=ce.
- Control priority on each rising clk edge (clr low): s > ld > ce. Direction is sampled on the same edge.
- s=1: every digit becomes BASE-1, regardless of ce, ld or up. WRAP=0.
- ld=1, s=0: digit k takes D digit k. Any loaded digit >= BASE is clamped to BASE-1. Load ignores ce. WRAP=0.
- Counting (ce=1, s=0, ld=0), up=1:
  - Digit 0 increments.
  - Digit k increments only when all lower digits equal BASE-1.
  - A digit at BASE-1 that increments rolls to 0.
- Counting, up=0:
  - Digit 0 decrements.
  - Digit k decrements only when all lower digits equal 0.
  - A digit at 0 that decrements rolls to BASE-1.
- ce=0 with s=0 and ld=0: Q holds. WRAP=0.
- Digit carry and borrow are combinational ripple within one cycle; the whole counter updates on one edge.
- TC is combinational from the current Q and up:
  - up=1: TC=1 when all digits equal BASE-1.
  - up=0: TC=1 when all digits equal 0.
- CEO = ce & TC, combinational. It must not depend on s or ld.
- WRAP: registered. It is 1 for exactly the cycle after an edge where counting happened with TC=1 (all-max to 0 going up, or all-zero to all-max going down). Otherwise it is 0.
- Direction change mid-count: no extra latency; the next edge counts in the new direction from the held value.
- Full count sequence length is BASE^NDIG.
- clr asserted mid-count: immediate clear. On release, the first enabled edge gives Q=1 (up) or all-max (down).
- Illegal values: if the state holds a digit >= BASE (unreachable except by parameter misuse), the next count brings that digit back in range. Up: the digit rolls to 0 and carries like BASE-1. Down: it decrements normally.
- Elaboration must fail if BASE > 2^DW or BASE < 2.

Test Plan:
- NDIG=2, BASE=10, up=1, ce=1; pulse clr, release. → Q=0x00; after 99 edges Q=0x99 with TC=1 and CEO=1; next edge Q=0x00 and WRAP=1 for one cycle.
- BASE=10, hold at 0x00, up=0, ce=1, one edge. → Q=0x99, WRAP=1 on the next cycle; TC=1 while up=0 at 0x00.
- Sync set at time 100 for 15 ns (s=1), with ce=1 and up=1. → Q=0x99 on the edge, TC=1; the first edge after s falls gives Q=0x00 and WRAP=1.
- ld=1 with D=0x3C (BASE=10). → Q=0x39 because the low digit is clamped. Same edge with s=1 as well. → Q=0x99 (s wins).
- NDIG=2, BASE=16, up=1, count from 0x0F. → 0x10 (hex carry); ce=0 holds Q and forces CEO=0 even when TC=1 at 0xFF.
- Assert clr asynchronously mid-cycle at Q=0x57. → Q=0x00 before the next edge, WRAP=0; cascade two instances (CEO of one to ce of the next) and check 4-digit rollover 9999 → 0000.
